result_stream_sink: RTL and testbench

- Consumer end of the PE result-cache readout stream (top_rd_sop/eop/vld/data/err).
- On a host start pulse it issues a one-cycle read request, then accepts a 32-word burst.
- Each word carries two 16-bit PE results; the block unpacks them into a 64-entry result buffer and checks packet framing.
- It exposes the buffer to a host through a registered read port and reports done/error status.

---
 rtl/result_stream_sink.sv | 185 ++++++++++++++++++
 tb/tb_result_stream_sink.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_stream_sink.sv
// -----------------------------------------------------------------------------
// result_stream_sink
//
// Consumer end of the PE result-cache readout stream. A host start pulse
// issues a one-cycle read request (top_rd_sop). The block then accepts a
// burst of WORDS 32-bit words. Each word carries two 16-bit PE results,
// which are unpacked into a 2*WORDS entry result buffer. Packet framing is
// checked while the burst arrives. The buffer is exposed to the host through
// a registered read port.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           host pulse, begins a readout (honoured only in IDLE)
//   top_rd_sop      one-cycle read request to the result cache
//   top_rd_vld      data word valid
//   top_rd_data     {elem[2k+1], elem[2k]} for word k
//   top_rd_eop      last word of burst, qualified by top_rd_vld
//   top_rd_err      upstream error, honoured any cycle while receiving
//   busy            high while requesting or receiving
//   done            one-cycle pulse at burst end (clean or errored)
//   err_flags       sticky: [0] early eop, [1] missing eop, [2] timeout,
//                   [3] upstream error
//   word_cnt        words accepted in the current/last burst (0..WORDS)
//   host_rd_addr    element index = row*8+col
//   host_rd_data    buffer[host_rd_addr], registered, 1-cycle latency
// -----------------------------------------------------------------------------
module result_stream_sink #(
    parameter int WORDS   = 32,
    parameter int TIMEOUT = 256,
    parameter int TW      = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        top_rd_sop,
    input  logic        top_rd_vld,
    input  logic [31:0] top_rd_data,
    input  logic        top_rd_eop,
    input  logic        top_rd_err,
    output logic        busy,
    output logic        done,
    output logic [3:0]  err_flags,
    output logic [5:0]  word_cnt,
    input  logic [5:0]  host_rd_addr,
    output logic [15:0] host_rd_data
);

    localparam logic [5:0]    LAST_WORD = 6'(WORDS - 1);
    localparam logic [5:0]    FULL_CNT  = 6'(WORDS);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    localparam int FLAG_EARLY_EOP   = 0;
    localparam int FLAG_MISSING_EOP = 1;
    localparam int FLAG_TIMEOUT     = 2;
    localparam int FLAG_UPSTREAM    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RECV,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    word_cnt_q, word_cnt_d;
    logic [3:0]    err_flags_q, err_flags_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0]   host_rd_data_q, host_rd_data_d;

    // Result buffer: deliberately not reset, it only holds data.
    logic [15:0]   mem_q [0:63];

    logic          wr_en;
    logic [4:0]    wr_idx;

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        err_flags_d = err_flags_q;
        tmo_cnt_d   = tmo_cnt_q;
        wr_en       = 1'b0;
        wr_idx      = word_cnt_q[4:0];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_REQ;
                    word_cnt_d  = '0;
                    err_flags_d = '0;
                end
            end

            ST_REQ: begin
                state_d   = ST_RECV;
                tmo_cnt_d = '0;
            end

            ST_RECV: begin
                // Storing a word is independent of how the burst ends: a
                // valid word is kept even in the cycle that terminates it.
                // The count guard keeps the write address inside the buffer.
                if (top_rd_vld) begin
                    tmo_cnt_d = '0;
                    if (word_cnt_q < FULL_CNT) begin
                        wr_en      = ~rst;
                        word_cnt_d = word_cnt_q + 6'd1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end

                // Termination checks in priority order.
                if (top_rd_err) begin
                    err_flags_d[FLAG_UPSTREAM] = 1'b1;
                    state_d                    = ST_DONE;
                end else if (top_rd_vld && top_rd_eop) begin
                    if (word_cnt_q != LAST_WORD) begin
                        err_flags_d[FLAG_EARLY_EOP] = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (top_rd_vld && (word_cnt_q == LAST_WORD)) begin
                    err_flags_d[FLAG_MISSING_EOP] = 1'b1;
                    state_d                       = ST_DONE;
                end else if (!top_rd_vld && (tmo_cnt_q == TMO_LAST)) begin
                    err_flags_d[FLAG_TIMEOUT] = 1'b1;
                    state_d                   = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered host read; the buffer is read before this edge's write
    // lands, so a same-address write returns the old contents.
    always_comb begin
        host_rd_data_d = mem_q[host_rd_addr];
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            word_cnt_q     <= '0;
            err_flags_q    <= '0;
            tmo_cnt_q      <= '0;
            host_rd_data_q <= '0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            err_flags_q    <= err_flags_d;
            tmo_cnt_q      <= tmo_cnt_d;
            host_rd_data_q <= host_rd_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Result buffer write: both halves of a word land in one cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_idx, 1'b0}] <= top_rd_data[15:0];
            mem_q[{wr_idx, 1'b1}] <= top_rd_data[31:16];
        end
    end

    assign top_rd_sop   = (state_q == ST_REQ);
    assign busy         = (state_q == ST_REQ) || (state_q == ST_RECV);
    assign done         = (state_q == ST_DONE);
    assign err_flags    = err_flags_q;
    assign word_cnt     = word_cnt_q;
    assign host_rd_data = host_rd_data_q;

endmodule

// File: tb/tb_result_stream_sink.sv
// -----------------------------------------------------------------------------
// tb_result_stream_sink
//
// Drives directed and randomized readout bursts into result_stream_sink and
// compares termination timing, status and buffer contents with a
// behavioural reference model of the burst rules.
// -----------------------------------------------------------------------------
module tb_result_stream_sink;

    localparam int WORDS   = 32;
    localparam int TIMEOUT = 256;
    localparam int TW      = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        top_rd_sop;
    logic        top_rd_vld;
    logic [31:0] top_rd_data;
    logic        top_rd_eop;
    logic        top_rd_err;
    logic        busy;
    logic        done;
    logic [3:0]  err_flags;
    logic [5:0]  word_cnt;
    logic [5:0]  host_rd_addr;
    logic [15:0] host_rd_data;

    always #5 clk = ~clk;

    result_stream_sink #(
        .WORDS  (WORDS),
        .TIMEOUT(TIMEOUT),
        .TW     (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .top_rd_sop  (top_rd_sop),
        .top_rd_vld  (top_rd_vld),
        .top_rd_data (top_rd_data),
        .top_rd_eop  (top_rd_eop),
        .top_rd_err  (top_rd_err),
        .busy        (busy),
        .done        (done),
        .err_flags   (err_flags),
        .word_cnt    (word_cnt),
        .host_rd_addr(host_rd_addr),
        .host_rd_data(host_rd_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          vld;
        bit          eop;
        bit          err;
        bit          st;
        logic [31:0] data;
    } beat_t;

    beat_t       beats[$];
    logic [15:0] ref_mem   [64];
    bit          ref_known [64];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        start       = 1'b0;
        top_rd_vld  = 1'b0;
        top_rd_eop  = 1'b0;
        top_rd_err  = 1'b0;
        top_rd_data = $urandom;
    endtask

    task automatic push(input bit v, input bit e, input bit r, input bit s, input logic [31:0] d);
        beat_t b;
        b.vld  = v;
        b.eop  = e;
        b.err  = r;
        b.st   = s;
        b.data = d;
        beats.push_back(b);
    endtask

    // Reference: walk the beat list cycle by cycle from the first receive
    // cycle, store words while fewer than WORDS are held, and stop at the
    // first beat that ends the burst. Beyond the list the line is idle.
    task automatic model(output int term, output logic [3:0] flags, output int cnt);
        int tmo;
        int i;
        tmo   = 0;
        i     = 0;
        cnt   = 0;
        flags = 4'h0;
        term  = -1;
        while (term < 0) begin
            beat_t b;
            if (i < beats.size()) begin
                b = beats[i];
            end else begin
                b.vld = 0; b.eop = 0; b.err = 0; b.st = 0; b.data = 32'h0;
            end
            if (b.vld && cnt < WORDS) begin
                ref_mem[2*cnt]     = b.data[15:0];
                ref_mem[2*cnt+1]   = b.data[31:16];
                ref_known[2*cnt]   = 1'b1;
                ref_known[2*cnt+1] = 1'b1;
                cnt++;
            end
            if (b.err) begin
                flags = 4'b1000;
                term  = i;
            end else if (b.vld && b.eop) begin
                flags = (cnt == WORDS) ? 4'b0000 : 4'b0001;
                term  = i;
            end else if (b.vld && cnt == WORDS) begin
                flags = 4'b0010;
                term  = i;
            end else if (b.vld) begin
                tmo = 0;
            end else if (tmo == TIMEOUT - 1) begin
                flags = 4'b0100;
                term  = i;
            end else begin
                tmo++;
            end
            i++;
        end
    endtask

    task automatic readback(input string name);
        for (int a = 0; a < 64; a++) begin
            host_rd_addr = 6'(a);
            tick;
            if (ref_known[a]) begin
                check_eq($sformatf("%s:rd%0d", name, a), 32'(host_rd_data), 32'(ref_mem[a]));
            end
        end
    endtask

    // Words presented while the block is not receiving must be dropped.
    task automatic junk(input int n);
        for (int k = 0; k < n; k++) begin
            top_rd_vld  = 1'b1;
            top_rd_eop  = 1'($urandom);
            top_rd_data = $urandom;
            tick;
        end
        idle_inputs;
    endtask

    task automatic run_burst(input string name, input bit start_in_done);
        int         term;
        int         cnt;
        int         seen;
        bit         busy_ok;
        logic [3:0] flags;
        model(term, flags, cnt);

        check_eq({name, ":sop_idle"}, 32'(top_rd_sop), 32'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        check_eq({name, ":sop"}, 32'(top_rd_sop), 32'd1);
        check_eq({name, ":busy_req"}, 32'(busy), 32'd1);
        tick;
        check_eq({name, ":sop_len"}, 32'(top_rd_sop), 32'd0);

        seen    = -1;
        busy_ok = 1'b1;
        for (int s = 0; s < beats.size() + TIMEOUT + 8; s++) begin
            if (s < beats.size()) begin
                start       = beats[s].st;
                top_rd_vld  = beats[s].vld;
                top_rd_eop  = beats[s].eop;
                top_rd_err  = beats[s].err;
                top_rd_data = beats[s].data;
            end else begin
                idle_inputs;
            end
            tick;
            if (done) begin
                seen = s;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        idle_inputs;

        check_eq({name, ":done_at"}, 32'(seen), 32'(term));
        check_eq({name, ":busy_recv"}, 32'(busy_ok), 32'd1);
        check_eq({name, ":busy_done"}, 32'(busy), 32'd0);
        check_eq({name, ":flags"}, 32'(err_flags), 32'(flags));
        check_eq({name, ":cnt"}, 32'(word_cnt), 32'(cnt));

        if (start_in_done) start = 1'b1;
        tick;
        start = 1'b0;
        check_eq({name, ":done_len"}, 32'(done), 32'd0);
        check_eq({name, ":idle_sop"}, 32'(top_rd_sop), 32'd0);
        check_eq({name, ":idle_busy"}, 32'(busy), 32'd0);
        check_eq({name, ":flags_hold"}, 32'(err_flags), 32'(flags));
        check_eq({name, ":cnt_hold"}, 32'(word_cnt), 32'(cnt));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;
        bit seen_busy;

        for (int a = 0; a < 64; a++) begin
            ref_known[a] = 1'b0;
            ref_mem[a]   = 16'h0;
        end
        rst          = 1'b1;
        host_rd_addr = 6'd0;
        idle_inputs;
        repeat (3) tick;
        check_eq("rst:sop", 32'(top_rd_sop), 32'd0);
        check_eq("rst:busy", 32'(busy), 32'd0);
        check_eq("rst:done", 32'(done), 32'd0);
        check_eq("rst:flags", 32'(err_flags), 32'd0);
        check_eq("rst:cnt", 32'(word_cnt), 32'd0);
        check_eq("rst:rdata", 32'(host_rd_data), 32'd0);
        rst = 1'b0;
        tick;

        // Nominal back-to-back burst: element i holds value i.
        beats.delete();
        for (int k = 0; k < WORDS; k++) push(1, k == WORDS - 1, 0, 0, {16'(2*k+1), 16'(2*k)});
        run_burst("nominal", 0);
        readback("nominal");

        // Same data with 10 idle cycles between words.
        beats.delete();
        for (int k = 0; k < WORDS; k++) begin
            if (k > 0) for (int g = 0; g < 10; g++) push(0, 0, 0, 0, $urandom);
            push(1, k == WORDS - 1, 0, 0, {16'(2*k+1), 16'(2*k)});
        end
        run_burst("gapped", 0);

        // Early eop on word 9: elements 20.. keep earlier values.
        beats.delete();
        for (int k = 0; k < 10; k++) push(1, k == 9, 0, 0, $urandom);
        run_burst("early_eop", 0);
        junk(3);
        readback("early_eop");

        // Missing eop: 32 words without eop, then stray words are dropped.
        beats.delete();
        for (int k = 0; k < WORDS; k++) push(1, 0, 0, 0, $urandom);
        run_burst("no_eop", 0);
        junk(3);
        readback("no_eop");

        // Timeout: request then silence.
        beats.delete();
        run_burst("timeout", 0);

        // Upstream error on word 5 together with vld; start mid-burst and
        // during DONE are ignored.
        beats.delete();
        for (int k = 0; k < 6; k++) push(1, 0, k == 5, k == 2, $urandom);
        run_burst("up_err", 1);
        readback("up_err");

        // Clean burst after the error run clears the flags.
        beats.delete();
        for (int k = 0; k < WORDS; k++) push(1, k == WORDS - 1, 0, 0, $urandom);
        run_burst("restart", 0);
        readback("restart");

        // Reset after 12 words.
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        for (int k = 0; k < 12; k++) begin
            top_rd_vld  = 1'b1;
            top_rd_data = $urandom;
            ref_mem[2*k]   = top_rd_data[15:0];
            ref_mem[2*k+1] = top_rd_data[31:16];
            tick;
        end
        top_rd_vld = 1'b0;
        rst        = 1'b1;
        tick;
        rst = 1'b0;
        check_eq("midrst:busy", 32'(busy), 32'd0);
        check_eq("midrst:cnt", 32'(word_cnt), 32'd0);
        check_eq("midrst:flags", 32'(err_flags), 32'd0);
        check_eq("midrst:done", 32'(done), 32'd0);
        check_eq("midrst:rdata", 32'(host_rd_data), 32'd0);
        seen_done = 1'b0;
        seen_busy = 1'b0;
        for (int k = 12; k < WORDS; k++) begin
            top_rd_vld  = 1'b1;
            top_rd_eop  = (k == WORDS - 1);
            top_rd_data = $urandom;
            tick;
            if (done) seen_done = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        idle_inputs;
        tick;
        check_eq("midrst:no_done", 32'(seen_done), 32'd0);
        check_eq("midrst:no_busy", 32'(seen_busy), 32'd0);
        check_eq("midrst:cnt_after", 32'(word_cnt), 32'd0);
        readback("midrst");

        // Randomized bursts: gaps, eop placement, missing eop, upstream errors.
        for (int t = 0; t < 12; t++) begin
            int n;
            int errat;
            bit noeop;
            beats.delete();
            n     = $urandom_range(1, 34);
            errat = ($urandom % 5 == 0) ? int'($urandom_range(0, n - 1)) : -1;
            noeop = ($urandom % 4 == 0);
            for (int k = 0; k < n; k++) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) push(0, 0, 0, ($urandom % 8 == 0), $urandom);
                push(1, (k == n - 1) && !noeop, k == errat, ($urandom % 8 == 0), $urandom);
            end
            run_burst($sformatf("rand%0d", t), ($urandom % 2 == 0));
            if (t % 3 == 0) junk(2);
            readback($sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
